// File: rtl/counter_w_flag_p.sv
// Free-running modulo-MAXIMUM_VALUE up-counter with a registered terminal-count flag.
// The flag is computed from the next count so it changes on the same edge as the counter.
module counter_w_flag_p #(
    parameter  int unsigned MAXIMUM_VALUE = 16,
    localparam int unsigned NBITS         = (MAXIMUM_VALUE > 2) ? $clog2(MAXIMUM_VALUE) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             flag,
    output logic [NBITS-1:0] counter
);

    localparam logic [NBITS-1:0] TERMINAL = NBITS'(MAXIMUM_VALUE - 1);

    logic [NBITS-1:0] r_counter;
    logic             r_flag;

    logic             w_at_terminal;
    logic [NBITS-1:0] w_counter_next;
    logic             w_flag_next;

    // Explicit wrap keeps non-power-of-2 moduli inside 0..MAXIMUM_VALUE-1.
    always_comb begin
        w_at_terminal  = 1'b0;
        w_counter_next = r_counter;
        w_flag_next    = r_flag;

        w_at_terminal = (r_counter == TERMINAL);
        if (enable) begin
            w_counter_next = w_at_terminal ? '0 : (r_counter + NBITS'(1));
            w_flag_next    = (w_counter_next == TERMINAL);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter <= '0;
            r_flag    <= 1'b0;
        end else begin
            r_counter <= w_counter_next;
            r_flag    <= w_flag_next;
        end
    end

    assign counter = r_counter;
    assign flag    = r_flag;

endmodule

// File: tb/tb_counter_w_flag_p.sv
// Bench for counter_w_flag_p at moduli 16, 10 and 2: a directed vector table for the
// default modulus, corner-case sequences, and randomized reset/enable against a modulo model.
module tb_counter_w_flag_p;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b1;

    logic [3:0] cnt16;
    logic       flg16;
    logic [3:0] cnt10;
    logic       flg10;
    logic [0:0] cnt2;
    logic       flg2;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference state: the count as a plain integer modulo the modulus.
    int unsigned m16 = 0;
    int unsigned m10 = 0;
    int unsigned m2  = 0;

    counter_w_flag_p #(.MAXIMUM_VALUE(16)) u_dut16 (
        .clk(clk), .reset(reset), .enable(enable), .flag(flg16), .counter(cnt16));
    counter_w_flag_p #(.MAXIMUM_VALUE(10)) u_dut10 (
        .clk(clk), .reset(reset), .enable(enable), .flag(flg10), .counter(cnt10));
    counter_w_flag_p #(.MAXIMUM_VALUE(2)) u_dut2 (
        .clk(clk), .reset(reset), .enable(enable), .flag(flg2), .counter(cnt2));

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        int unsigned cnt;
        logic        flg;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge for all three instances, with model update and checks.
    task automatic step(input logic rst, input logic en);
        reset  = rst;
        enable = en;
        @(posedge clk);
        #1;
        if (rst) begin
            m16 = 0; m10 = 0; m2 = 0;
        end else if (en) begin
            m16 = (m16 + 1) % 16;
            m10 = (m10 + 1) % 10;
            m2  = (m2 + 1) % 2;
        end
        chk("cnt16", 32'(cnt16), m16);
        chk("flg16", 32'(flg16), 32'(m16 == 15));
        chk("cnt10", 32'(cnt10), m10);
        chk("flg10", 32'(flg10), 32'(m10 == 9));
        chk("cnt10_range", 32'(cnt10 < 4'd10), 32'd1);
        chk("cnt2", 32'(cnt2), m2);
        chk("flg2", 32'(flg2), 32'(m2 == 1));
        chk("flg2_eq_cnt", 32'(flg2), 32'(cnt2));
    endtask

    initial begin
        int unsigned highs;
        int unsigned first_flag;

        // Directed table for the default modulus, values taken from the count rules.
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b1, 0, 1'b0});
        for (int i = 1; i <= 15; i++) tbl.push_back('{1'b0, 1'b1, i, 1'(i == 15)});
        tbl.push_back('{1'b0, 1'b1, 0, 1'b0});
        for (int i = 1; i <= 7; i++) tbl.push_back('{1'b0, 1'b1, i, 1'b0});
        for (int i = 0; i < 5; i++) tbl.push_back('{1'b0, 1'b0, 7, 1'b0});
        for (int i = 8; i <= 15; i++) tbl.push_back('{1'b0, 1'b1, i, 1'(i == 15)});
        for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 1'b0, 15, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 0, 1'b0});
        for (int i = 1; i <= 15; i++) tbl.push_back('{1'b0, 1'b1, i, 1'(i == 15)});
        tbl.push_back('{1'b1, 1'b1, 0, 1'b0});
        tbl.push_back('{1'b1, 1'b0, 0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 2, 1'b0});

        #2;
        foreach (tbl[k]) begin
            step(tbl[k].rst, tbl[k].en);
            chk($sformatf("tbl_cnt[%0d]", k), 32'(cnt16), tbl[k].cnt);
            chk($sformatf("tbl_flg[%0d]", k), 32'(flg16), 32'(tbl[k].flg));
        end

        // First-flag latency and flag period over three full periods.
        step(1'b1, 1'b1);
        highs = 0;
        first_flag = 0;
        for (int e = 1; e <= 48; e++) begin
            step(1'b0, 1'b1);
            if (flg16 === 1'b1) begin
                highs++;
                if (first_flag == 0) first_flag = e;
            end
        end
        chk("flag_highs_3_periods", highs, 32'd3);
        chk("first_flag_edge", first_flag, 32'd15);

        // Mid-count reset while flag is high; enable dropped at terminal holds flag.
        for (int e = 0; e < 15; e++) step(1'b0, 1'b1);
        chk("pre_reset_flag", 32'(flg16), 32'd1);
        step(1'b0, 1'b0);
        chk("hold_term_flag", 32'(flg16), 32'd1);
        step(1'b1, 1'b0);
        chk("reset_term_cnt", 32'(cnt16), 32'd0);
        chk("reset_term_flg", 32'(flg16), 32'd0);

        // Randomized reset/enable against the modulo model.
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
